// File: rtl/ecg_sample_buffer.sv
// ECG sample FIFO with fixed-rate pacing and sticky overflow/underrun flags.
// Optional build macro ECG_BUF_DROP_CNT_EN adds a saturating dropped-sample counter.
module ecg_sample_buffer #(
  parameter int DW         = 11,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 277778
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       en,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  input  logic                       out_ready,
  output logic                       fifo_e,
  output logic                       fifo_f,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
`ifdef ECG_BUF_DROP_CNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  output logic                       udr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [LW-1:0] level_r, level_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [DW-1:0] out_data_r;
  logic          out_valid_r, ovf_r, udr_r, fifo_e_r, fifo_f_r;
  logic          tick_s, wr_s, pop_s, drop_s;

  // Full/empty come from the registered level, so a write on full is dropped even with a same-cycle pop.
  assign tick_s = en && (cnt_r == CNT_MAX);
  assign wr_s   = in_valid && !fifo_f_r;
  assign drop_s = in_valid && fifo_f_r;
  assign pop_s  = tick_s && !out_valid_r && !fifo_e_r;

  // Next-state for occupancy and pacing counter.
  always_comb begin
    level_nxt_s = level_r;
    cnt_nxt_s   = cnt_r;
    case ({wr_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
    if (!en) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (tick_s) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Sample storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (wr_s && !flush) begin
      mem[wptr_r] <= in_data;
    end
  end

  // Control state; flush outranks every other update but leaves out_data alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      ovf_r       <= 1'b0;
      udr_r       <= 1'b0;
      fifo_e_r    <= 1'b1;
      fifo_f_r    <= 1'b0;
    end else if (flush) begin
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      udr_r       <= 1'b0;
      fifo_e_r    <= 1'b1;
      fifo_f_r    <= 1'b0;
    end else begin
      level_r  <= level_nxt_s;
      cnt_r    <= cnt_nxt_s;
      fifo_e_r <= (level_nxt_s == {LW{1'b0}});
      fifo_f_r <= (level_nxt_s == LVL_FULL);
      if (wr_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      if (tick_s && !out_valid_r && fifo_e_r) begin
        udr_r <= 1'b1;
      end
      if (pop_s) begin
        out_data_r  <= mem[rptr_r];
        out_valid_r <= 1'b1;
        rptr_r      <= rptr_r + AW'(1);
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef ECG_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of samples lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'h00;
    end else if (flush) begin
      drop_cnt_r <= 8'h00;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'h01;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign fifo_e    = fifo_e_r;
  assign fifo_f    = fifo_f_r;
  assign level     = level_r;
  assign ovf       = ovf_r;
  assign udr       = udr_r;

endmodule

// File: tb/tb_ecg_sample_buffer.sv
// Randomized and directed bench for ecg_sample_buffer against a queue-based reference model.
module tb_ecg_sample_buffer;

  localparam int DW = 11;
  localparam int DEPTH = 16;
  localparam int SDIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          fifo_e, fifo_f, ovf, udr;
  logic [4:0]    level;
`ifdef ECG_BUF_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  ecg_sample_buffer #(.DW(DW), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .en(en), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fifo_e(fifo_e), .fifo_f(fifo_f), .level(level),
    .ovf(ovf),
`ifdef ECG_BUF_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .udr(udr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [DW-1:0] m_q[$];
  int            m_phase = 0;
  bit            m_ov = 1'b0;
  logic [DW-1:0] m_od = '0;
  bit            m_ovf = 1'b0;
  bit            m_udr = 1'b0;
  int            m_drop = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_ov = 1'b0; m_od = '0; m_ovf = 1'b0; m_udr = 1'b0; m_drop = 0;
  endtask

  // Apply one clock of the behavioural rules using the inputs present at the edge.
  task automatic model_step();
    bit full, empty, tick;
    if (flush) begin
      m_q.delete();
      m_phase = 0; m_ov = 1'b0; m_ovf = 1'b0; m_udr = 1'b0; m_drop = 0;
      return;
    end
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    tick  = en && (m_phase == SDIV - 1);
    if (tick && !m_ov && !empty) begin
      m_od = m_q.pop_front();
      m_ov = 1'b1;
    end else begin
      if (tick && !m_ov && empty) m_udr = 1'b1;
      if (m_ov && out_ready) m_ov = 1'b0;
    end
    if (in_valid) begin
      if (full) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        m_q.push_back(in_data);
      end
    end
    m_phase = en ? ((m_phase + 1) % SDIV) : 0;
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("level", level, m_q.size());
    check("fifo_e", fifo_e, m_q.size() == 0);
    check("fifo_f", fifo_f, m_q.size() == DEPTH);
    check("ovf", ovf, m_ovf);
    check("udr", udr, m_udr);
`ifdef ECG_BUF_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input int d, input bit e, input bit r, input bit f);
    in_valid = v; in_data = DW'(d); en = e; out_ready = r; flush = f;
  endtask

  task automatic do_flush();
    drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
    cycle();
    flush = 1'b0;
  endtask

  int wr_pct[4] = '{10, 40, 80, 97};
  int guard;

  initial begin
    model_reset();
    repeat (2) cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_e", fifo_e, 1);
    check("rst_level", level, 0);
    rst_n = 1'b1;
    cycle();

    // 17 writes with pacing disabled: last one is dropped
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, i, 1'b0, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("fill_level", level, 16);
    check("fill_full", fifo_f, 1);
    check("fill_ovf", ovf, 1);

    // three samples released on ticks, then an underrun tick
    do_flush();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 1'b0, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
    repeat (18) cycle();
    check("pace_last", out_data, 3);
    check("pace_udr", udr, 1);
    check("pace_valid", out_valid, 0);

    // consumer stall holds the first sample
    do_flush();
    drive(1'b1, 11'h0A5, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 11'h05A, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    repeat (14) cycle();
    check("stall_data", out_data, 11'h0A5);
    check("stall_level", level, 1);
    out_ready = 1'b1;
    repeat (6) cycle();
    check("stall_next", out_data, 11'h05A);

    // flush with level=5, out_valid=1 and a same-cycle write
    do_flush();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 11'h100 + i, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin cycle(); guard++; end
    check("fl_setup_valid", out_valid, 1);
    check("fl_setup_level", level, 5);
    drive(1'b1, 11'h3FF, 1'b1, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("fl_level", level, 0);
    check("fl_valid", out_valid, 0);
    check("fl_ovf", ovf, 0);

`ifdef ECG_BUF_DROP_CNT_EN
    for (int i = 0; i < DEPTH + 300; i++) begin
      drive(1'b1, i, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("drop_sat", drop_cnt, 8'hFF);
    do_flush();
    check("drop_flush", drop_cnt, 0);
`endif

    // randomized traffic at several write rates, with one mid-run async reset
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 400; c++) begin
        drive($urandom_range(0, 99) < wr_pct[s], $urandom, $urandom_range(0, 19) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
        cycle();
      end
      if (s == 1) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle();
        #2 rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
